doppler_tone_gen: RTL and testbench
===================================

Name: doppler_tone_gen

Overview:
Settings-bus-controlled complex tone generator for the Doppler tracker chain. It synthesizes a 16-bit I/Q sinusoid using a 32-bit phase accumulator and a quarter-wave sine LUT. It can linearly sweep the frequency word to emulate Doppler drift and emits fixed-length AXI-stream packets. It feeds axi_wrapper s_axis_data as loopback or test stimulus for the tracker.

Parameters:
LUT_BITS, 8, log2 of quarter-wave resolution; LUT holds 2^LUT_BITS+1 entries
SR_BASE, 200, first settings address; six consecutive addresses are used

Ports:
ce_clk  in  1  block clock; all logic runs on its rising edge
ce_rst_n  in  1  asynchronous, active-low reset
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
pps  in  1  synchronous PPS pulse, used for armed start
o_tdata  out  32  {I[31:16], Q[15:0]}, two's complement
o_tlast  out  1  asserted on the last sample of each packet
o_tvalid  out  1  output sample valid
o_tready  in  1  downstream ready
running  out  1  high while in ARMED, RUN or DRAIN
pkt_count  out  32  packets completed since the last start
cur_freq  out  32  frequency word applied to the next issued sample

Behaviour:
- Settings registers, all reset to 0:
  - SR_BASE+0 FREQ: start frequency word.
  - +1 RATE: signed per-sample frequency step.
  - +2 SPP: 16 bits; values 0 or 1 mean every sample carries tlast.
  - +3 AMP: 16 bits; values above 0x8000 saturate to 0x8000, which is unity.
  - +4 NUM_PKTS: 0 means continuous.
  - +5 CTRL: bit0 enable, bit1 arm on PPS, bit2 sweep enable.
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, running=0, pkt_count=0, cur_freq=0, FSM=IDLE.
- FSM transitions:
  - IDLE: on a CTRL write with bit0=1, clear phase, pkt_count and sample counter, and load cur_freq=FREQ. Go to ARMED if bit1=1, otherwise go to RUN.
  - ARMED: pps is registered once. On the rising edge seen at cycle t, go to RUN at t+1. Clearing enable returns to IDLE.
  - RUN: issue one sample per cycle in which the pipeline advances.
    - If enable is cleared, go to DRAIN.
    - When the packet count reaches NUM_PKTS (NUM_PKTS≠0), go to IDLE after the final tlast sample is issued.
  - DRAIN: keep issuing samples until the current packet's tlast sample is issued, then go to IDLE. If the packet boundary has just been hit, go straight to IDLE.
- Issue step, per sample:
  - phase <= phase + cur_freq, mod 2^32.
  - If sweep is enabled, cur_freq <= cur_freq + RATE, wrapping mod 2^32 with no saturation.
  - The sample counter increments; at SPP it sets tlast, resets to 0 and increments pkt_count.
  - FREQ writes during RUN take effect on the next issued sample only when sweep is disabled.
- Pipeline: 3 stages (quadrant/index decode → LUT read → amplitude multiply → output register).
  - Global advance: adv = ~o_tvalid | o_tready. All stages, the phase and the counters hold when adv=0.
  - A sample issued at cycle t appears on o_tdata at t+3, assuming no stall.
  - tdata and tlast stay stable while o_tvalid=1 and o_tready=0. No sample is dropped or duplicated.
- Sine/cosine:
  - Q = sin(phase), I = sin(phase + 2^30).
  - q = phase[31:30], i = phase[29:30-LUT_BITS], N = 2^LUT_BITS.
  - Quadrant 0 → lut[i]; 1 → lut[N-i]; 2 → -lut[i]; 3 → -lut[N-i].
  - lut[k] = round(32767·sin(π/2·k/N)).
- Amplitude: out = (lut·AMP)>>15, unsigned floor. Negation is applied after scaling. AMP=0x8000 returns the LUT value exactly.
- The pipeline flushes in-flight samples after entering IDLE. running deasserts when the last sample has been accepted.
- An asynchronous reset mid-packet clears everything immediately. No partial packet completion is required.

Decomposition:
- Package doppler_tone_pkg: SR offset constants, CTRL bit indices, FSM state enum, unity-amplitude constant.
- One sub-module, doppler_sin_lut: registered quarter-wave ROM plus quadrant folding/sign, instantiated twice (I and Q).

Test Plan:
- Basic tone: FREQ=0x4000_0000, AMP=0x8000, SPP=4, CTRL=1 → (I,Q) = (32767,0),(0,32767),(−32767,0),(0,−32767), with tlast on every 4th sample. First tvalid arrives 3 cycles after RUN.
- Backpressure: same setup, o_tready low for 5 cycles after sample 2 → o_tdata/o_tlast held. Resumed sequence continues with (−32767,0), no gap or repeat.
- PPS arm: CTRL=0b011, pps pulse at cycle t → o_tvalid=0 before t+4, first sample at t+4, running=1 from the CTRL write.
- Finite burst: NUM_PKTS=2, SPP=3, AMP=0x4000 → exactly 6 samples with values in {0,±16383}, tlast on samples 3 and 6. Afterwards pkt_count=2 and running=0.
- Sweep wrap: FREQ=0xF000_0000, RATE=0x2000_0000, CTRL=0b101 → cur_freq after samples 1 and 2 is 0x1000_0000 then 0x3000_0000.
- Disable mid-packet: SPP=4, clear enable after 2 samples issued → 2 more samples, the last with tlast, then IDLE. Reset asserted mid-packet → outputs 0 the same cycle.

Source files
------------

// File: rtl/doppler_tone_pkg.sv
// doppler_tone_pkg
//   Shared definitions for the Doppler tone generator: settings-register
//   offsets, CTRL bit positions, the FSM state type, the unity amplitude
//   constant and the elaboration-time quarter-wave sine table builder.
package doppler_tone_pkg;

  // Offsets from the block's settings base address
  localparam int SR_FREQ     = 0;
  localparam int SR_RATE     = 1;
  localparam int SR_SPP      = 2;
  localparam int SR_AMP      = 3;
  localparam int SR_NUM_PKTS = 4;
  localparam int SR_CTRL     = 5;

  // CTRL register bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_ARM   = 1;
  localparam int CTRL_SWEEP = 2;

  // Amplitude word that passes LUT values through unchanged
  localparam logic [15:0] AMP_UNITY = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // round(32767 * sin(pi/2 * k / 2^lutBits)), evaluated once at elaboration.
  // Uses a Q30 Taylor series; ten terms are far below one LSB at x = pi/2.
  function automatic logic [14:0] lut_value(input int k, input int lutBits);
    longint x;
    longint term;
    longint sum;
    longint scaled;
    x    = (64'sd1686629713 * longint'(k)) / (longint'(1) << lutBits);
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scaled = (sum * 32767 + (longint'(1) << 29)) >>> 30;
    if (scaled < 0) scaled = 0;
    if (scaled > 32767) scaled = 32767;
    return scaled[14:0];
  endfunction

endpackage

// File: rtl/doppler_sin_lut.sv
// doppler_sin_lut
//   Registered quarter-wave sine ROM with quadrant folding. One instance
//   produces the magnitude and sign of sin() for one channel.
//   Ports:
//     clk_i, rst_ni  clock and asynchronous active-low reset
//     en_i           pipeline advance; the output register holds when low
//     quad_i         phase quadrant (phase[31:30])
//     idx_i          index within the quadrant
//     mag_o          registered |sin| magnitude, 0..32767
//     neg_o          registered sign, high for quadrants 2 and 3
module doppler_sin_lut
  import doppler_tone_pkg::*;
#(
  parameter int LUT_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [1:0]          quad_i,
  input  logic [LUT_BITS-1:0] idx_i,
  output logic [14:0]         mag_o,
  output logic                neg_o
);

  localparam int N = 1 << LUT_BITS;

  logic [14:0]       rom [0:N];
  logic [LUT_BITS:0] addr;

  // The table holds N+1 points so that the mirrored quadrants can reach
  // the full-scale entry at k = N.
  for (genvar k = 0; k <= N; k++) begin : gRom
    localparam logic [14:0] RomVal = lut_value(k, LUT_BITS);
    assign rom[k] = RomVal;
  end

  // Odd quadrants run the quarter wave backwards.
  assign addr = quad_i[0] ? ((LUT_BITS+1)'(N) - {1'b0, idx_i}) : {1'b0, idx_i};

  // ROM read register; the sign simply follows the upper quadrant bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag_o <= '0;
      neg_o <= 1'b0;
    end else if (en_i) begin
      mag_o <= rom[addr];
      neg_o <= quad_i[1];
    end
  end

endmodule

// File: rtl/doppler_tone_gen.sv
// doppler_tone_gen
//   Settings-bus controlled complex tone generator with optional linear
//   frequency sweep, PPS-armed start and fixed-length AXI-stream packets.
//   Ports:
//     ce_clk, ce_rst_n             clock and asynchronous active-low reset
//     set_stb/set_addr/set_data    settings register writes
//     pps                          PPS pulse used for armed start
//     o_tdata/o_tlast/o_tvalid     output stream, tdata = {I, Q}
//     o_tready                     downstream ready
//     running                      busy, including in-flight samples
//     pkt_count                    packets completed since last start
//     cur_freq                     frequency word for the next sample
module doppler_tone_gen
  import doppler_tone_pkg::*;
#(
  parameter int LUT_BITS = 8,
  parameter int SR_BASE  = 200
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        pps,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        running,
  output logic [31:0] pkt_count,
  output logic [31:0] cur_freq
);

  logic [31:0] freq_q, rate_q, numPkts_q;
  logic [15:0] spp_q, amp_q;
  logic [2:0]  ctrl_q;
  logic        wrCtrl;

  state_e      state_q;
  logic [31:0] phase_q, curFreq_q, pktCount_q;
  logic [15:0] sampleCnt_q, sppEff;
  logic        ppsSync_q, ppsPrev_q, ppsRise;
  logic        adv, issue, lastSample_d, finalPkt_d;

  logic                s1Valid_q, s1Last_q, s2Valid_q, s2Last_q;
  logic [LUT_BITS+1:0] s1Phase_q, iPhase;
  logic [14:0]         magI, magQ;
  logic                negI, negQ;
  logic [15:0]         scaledI, scaledQ, sampleI_d, sampleQ_d;

  assign wrCtrl = set_stb && (set_addr == 8'(SR_BASE + SR_CTRL));

  // Settings registers; amplitude is clamped to unity as it is written.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      freq_q    <= '0;
      rate_q    <= '0;
      spp_q     <= '0;
      amp_q     <= '0;
      numPkts_q <= '0;
      ctrl_q    <= '0;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_BASE + SR_FREQ)) freq_q <= set_data;
      if (set_addr == 8'(SR_BASE + SR_RATE)) rate_q <= set_data;
      if (set_addr == 8'(SR_BASE + SR_SPP)) spp_q <= set_data[15:0];
      if (set_addr == 8'(SR_BASE + SR_AMP))
        amp_q <= (set_data[15:0] > AMP_UNITY) ? AMP_UNITY : set_data[15:0];
      if (set_addr == 8'(SR_BASE + SR_NUM_PKTS)) numPkts_q <= set_data;
      if (wrCtrl) ctrl_q <= set_data[2:0];
    end
  end

  // SPP of 0 or 1 both mean one sample per packet.
  assign sppEff       = (spp_q < 16'd2) ? 16'd1 : spp_q;
  assign lastSample_d = (sampleCnt_q == sppEff - 16'd1);
  assign finalPkt_d   = (numPkts_q != 32'd0) && (pktCount_q + 32'd1 == numPkts_q);
  assign ppsRise      = ppsSync_q & ~ppsPrev_q;
  assign adv          = ~o_tvalid | o_tready;

  // RUN issues only while enabled; DRAIN issues until the packet closes.
  assign issue = adv && (((state_q == ST_RUN) && ctrl_q[CTRL_EN]) ||
                         ((state_q == ST_DRAIN) && (sampleCnt_q != 16'd0)));

  // Control FSM with phase accumulator, frequency word and counters.
  // The start branch in IDLE is last so its clears take priority.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      curFreq_q   <= '0;
      pktCount_q  <= '0;
      sampleCnt_q <= '0;
      ppsSync_q   <= 1'b0;
      ppsPrev_q   <= 1'b0;
    end else begin
      ppsSync_q <= pps;
      ppsPrev_q <= ppsSync_q;
      if (issue) begin
        phase_q <= phase_q + curFreq_q;
        if (lastSample_d) begin
          sampleCnt_q <= '0;
          pktCount_q  <= pktCount_q + 32'd1;
        end else begin
          sampleCnt_q <= sampleCnt_q + 16'd1;
        end
      end
      // Without sweep the frequency word follows FREQ live.
      if (state_q != ST_IDLE) begin
        if (!ctrl_q[CTRL_SWEEP]) curFreq_q <= freq_q;
        else if (issue) curFreq_q <= curFreq_q + rate_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (wrCtrl && set_data[CTRL_EN]) begin
            phase_q     <= '0;
            pktCount_q  <= '0;
            sampleCnt_q <= '0;
            curFreq_q   <= freq_q;
            state_q     <= set_data[CTRL_ARM] ? ST_ARMED : ST_RUN;
          end
        end
        ST_ARMED: begin
          if (!ctrl_q[CTRL_EN]) state_q <= ST_IDLE;
          else if (ppsRise) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!ctrl_q[CTRL_EN])
            state_q <= (sampleCnt_q == 16'd0) ? ST_IDLE : ST_DRAIN;
          else if (issue && lastSample_d && finalPkt_d)
            state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if ((sampleCnt_q == 16'd0) || (issue && lastSample_d))
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Decode stage: capture the top phase bits of the issued sample.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1Phase_q <= '0;
    end else if (adv) begin
      s1Valid_q <= issue;
      s1Last_q  <= issue & lastSample_d;
      s1Phase_q <= phase_q[31 -: LUT_BITS+2];
    end
  end

  // Cosine is sine advanced by a quarter turn: bump the quadrant.
  assign iPhase = {s1Phase_q[LUT_BITS+1:LUT_BITS] + 2'd1, s1Phase_q[LUT_BITS-1:0]};

  doppler_sin_lut #(.LUT_BITS(LUT_BITS)) uLutI (
    .clk_i  (ce_clk),
    .rst_ni (ce_rst_n),
    .en_i   (adv),
    .quad_i (iPhase[LUT_BITS+1:LUT_BITS]),
    .idx_i  (iPhase[LUT_BITS-1:0]),
    .mag_o  (magI),
    .neg_o  (negI)
  );

  doppler_sin_lut #(.LUT_BITS(LUT_BITS)) uLutQ (
    .clk_i  (ce_clk),
    .rst_ni (ce_rst_n),
    .en_i   (adv),
    .quad_i (s1Phase_q[LUT_BITS+1:LUT_BITS]),
    .idx_i  (s1Phase_q[LUT_BITS-1:0]),
    .mag_o  (magQ),
    .neg_o  (negQ)
  );

  // Valid/last follow the LUT read stage.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
    end else if (adv) begin
      s2Valid_q <= s1Valid_q;
      s2Last_q  <= s1Last_q;
    end
  end

  // Unsigned floor scaling of the magnitude, then the sign is applied.
  always_comb begin
    scaledI   = 16'((32'(magI) * 32'(amp_q)) >> 15);
    scaledQ   = 16'((32'(magQ) * 32'(amp_q)) >> 15);
    sampleI_d = negI ? -scaledI : scaledI;
    sampleQ_d = negQ ? -scaledQ : scaledQ;
  end

  // Output register; holds its contents while the consumer stalls.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (adv) begin
      o_tvalid <= s2Valid_q;
      o_tlast  <= s2Last_q;
      o_tdata  <= {sampleI_d, sampleQ_d};
    end
  end

  assign running   = (state_q != ST_IDLE) | s1Valid_q | s2Valid_q | o_tvalid;
  assign pkt_count = pktCount_q;
  assign cur_freq  = curFreq_q;

endmodule

// File: tb/tb_doppler_tone_gen.sv
// tb_doppler_tone_gen
//   Scoreboard bench for doppler_tone_gen: each scenario queues its expected
//   {tlast, I, Q} words and a negedge monitor pops one per handshake.
module tb_doppler_tone_gen;
  import doppler_tone_pkg::*;

  localparam int SR_BASE = 200;

  logic        ce_clk   = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic        set_stb  = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        pps      = 1'b0;
  logic        o_tready = 1'b1;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        running;
  logic [31:0] pkt_count;
  logic [31:0] cur_freq;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          acceptCount = 0;
  bit          monEnable   = 1'b0;
  logic [32:0] expQ [$];

  doppler_tone_gen #(.LUT_BITS(8), .SR_BASE(SR_BASE)) dut (
    .ce_clk    (ce_clk),
    .ce_rst_n  (ce_rst_n),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .pps       (pps),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .running   (running),
    .pkt_count (pkt_count),
    .cur_freq  (cur_freq)
  );

  always #5 ce_clk = ~ce_clk;

  // One comparison: counts it, reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One settings-bus write, landing on the next rising edge.
  task automatic applyStimulus(input int offset, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(SR_BASE + offset);
    set_data = data;
    @(posedge ce_clk);
    #1;
    set_stb = 1'b0;
  endtask

  // Quarter-turn tone: (A,0), (0,A), (-A,0), (0,-A) repeating.
  task automatic pushTone(input int n, input int spp, input logic [15:0] amp);
    logic [15:0] iv;
    logic [15:0] qv;
    logic        lastBit;
    for (int k = 0; k < n; k++) begin
      case (k % 4)
        0:       begin iv = amp;  qv = 16'h0; end
        1:       begin iv = 16'h0; qv = amp;  end
        2:       begin iv = -amp; qv = 16'h0; end
        default: begin iv = 16'h0; qv = -amp; end
      endcase
      lastBit = ((k + 1) % spp) == 0;
      expQ.push_back({lastBit, iv, qv});
    end
  endtask

  // Waits, bounded, for the block to go quiet.
  task automatic waitIdle(input string name, input int budget);
    for (int c = 0; c < budget && running; c++) begin
      @(posedge ce_clk);
      #1;
    end
    checkOutput(name, 32'(running), 32'd0);
  endtask

  // Scoreboard monitor: a handshake is visible half a cycle before it lands.
  initial begin : monitor
    logic [32:0] expVal;
    forever begin
      @(negedge ce_clk);
      if (monEnable && ce_rst_n && o_tvalid && o_tready) begin
        acceptCount++;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_sample: got 0x%08h last %0b, expected no sample",
                   o_tdata, o_tlast);
        end else begin
          expVal = expQ.pop_front();
          checkOutput($sformatf("sample%0d_data", acceptCount), o_tdata, expVal[31:0]);
          checkOutput($sformatf("sample%0d_last", acceptCount), 32'(o_tlast), 32'(expVal[32]));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    repeat (3) @(posedge ce_clk);
    #1;
    ce_rst_n = 1'b1;
    @(posedge ce_clk);
    #1;

    // Reset state
    checkOutput("rst_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(o_tlast), 32'd0);
    checkOutput("rst_tdata", o_tdata, 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_pkt_count", pkt_count, 32'd0);
    checkOutput("rst_cur_freq", cur_freq, 32'd0);
    monEnable = 1'b1;

    // Basic tone, two packets of four, first valid three cycles after RUN
    applyStimulus(SR_FREQ, 32'h4000_0000);
    applyStimulus(SR_SPP, 32'd4);
    applyStimulus(SR_AMP, 32'h0000_8000);
    applyStimulus(SR_NUM_PKTS, 32'd2);
    pushTone(8, 4, 16'h7FFF);
    applyStimulus(SR_CTRL, 32'd1);
    checkOutput("basic_valid_c0", 32'(o_tvalid), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge ce_clk);
      #1;
      checkOutput($sformatf("basic_valid_c%0d", c), 32'(o_tvalid), 32'(c == 3));
    end
    waitIdle("basic_idle", 100);
    checkOutput("basic_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("basic_pkt_count", pkt_count, 32'd2);

    // Backpressure after the second accepted sample
    pushTone(8, 4, 16'h7FFF);
    acceptCount = 0;
    applyStimulus(SR_CTRL, 32'd1);
    for (int c = 0; c < 50 && acceptCount < 2; c++) begin
      @(posedge ce_clk);
      #1;
    end
    checkOutput("bp_two_accepted", 32'(acceptCount >= 2), 32'd1);
    o_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge ce_clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_valid", c), 32'(o_tvalid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_data", c), o_tdata, 32'h8001_0000);
      checkOutput($sformatf("bp_hold%0d_last", c), 32'(o_tlast), 32'd0);
    end
    o_tready = 1'b1;
    waitIdle("bp_idle", 100);
    checkOutput("bp_queue_empty", 32'(expQ.size()), 32'd0);

    // PPS-armed start: one packet of four
    applyStimulus(SR_NUM_PKTS, 32'd1);
    pushTone(4, 4, 16'h7FFF);
    applyStimulus(SR_CTRL, 32'd3);
    checkOutput("pps_running_armed", 32'(running), 32'd1);
    repeat (2) begin
      @(posedge ce_clk);
      #1;
    end
    checkOutput("pps_wait_valid", 32'(o_tvalid), 32'd0);
    pps = 1'b1;
    @(posedge ce_clk);
    #1;
    pps = 1'b0;
    checkOutput("pps_valid_t0", 32'(o_tvalid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge ce_clk);
      #1;
      checkOutput($sformatf("pps_valid_t%0d", c), 32'(o_tvalid), 32'(c == 4));
    end
    waitIdle("pps_idle", 100);
    checkOutput("pps_queue_empty", 32'(expQ.size()), 32'd0);

    // Finite burst at half amplitude
    applyStimulus(SR_SPP, 32'd3);
    applyStimulus(SR_AMP, 32'h0000_4000);
    applyStimulus(SR_NUM_PKTS, 32'd2);
    pushTone(6, 3, 16'h3FFF);
    applyStimulus(SR_CTRL, 32'd1);
    waitIdle("burst_idle", 100);
    checkOutput("burst_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("burst_pkt_count", pkt_count, 32'd2);

    // Disable after two issued samples: the packet still completes
    applyStimulus(SR_SPP, 32'd4);
    applyStimulus(SR_AMP, 32'h0001_0000);
    applyStimulus(SR_NUM_PKTS, 32'd0);
    pushTone(4, 4, 16'h0000);
    expQ.delete();
    applyStimulus(SR_AMP, 32'h0000_9000);
    pushTone(4, 4, 16'h7FFF);
    applyStimulus(SR_CTRL, 32'd1);
    @(posedge ce_clk);
    #1;
    applyStimulus(SR_CTRL, 32'd0);
    waitIdle("drain_idle", 100);
    repeat (5) @(posedge ce_clk);
    #1;
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_pkt_count", pkt_count, 32'd1);
    checkOutput("drain_no_valid", 32'(o_tvalid), 32'd0);

    // Sweep with mod-2^32 wrap of the frequency word
    monEnable = 1'b0;
    applyStimulus(SR_FREQ, 32'hF000_0000);
    applyStimulus(SR_RATE, 32'h2000_0000);
    applyStimulus(SR_SPP, 32'd1);
    applyStimulus(SR_CTRL, 32'd5);
    checkOutput("sweep_freq0", cur_freq, 32'hF000_0000);
    @(posedge ce_clk);
    #1;
    checkOutput("sweep_freq1", cur_freq, 32'h1000_0000);
    @(posedge ce_clk);
    #1;
    checkOutput("sweep_freq2", cur_freq, 32'h3000_0000);
    applyStimulus(SR_CTRL, 32'd0);
    waitIdle("sweep_idle", 100);

    // Asynchronous reset mid-packet
    applyStimulus(SR_FREQ, 32'h4000_0000);
    applyStimulus(SR_RATE, 32'd0);
    applyStimulus(SR_SPP, 32'd4);
    applyStimulus(SR_CTRL, 32'd1);
    repeat (5) @(posedge ce_clk);
    #1;
    checkOutput("arst_pre_valid", 32'(o_tvalid), 32'd1);
    #3;
    ce_rst_n = 1'b0;
    #1;
    checkOutput("arst_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("arst_tlast", 32'(o_tlast), 32'd0);
    checkOutput("arst_tdata", o_tdata, 32'd0);
    checkOutput("arst_running", 32'(running), 32'd0);
    checkOutput("arst_pkt_count", pkt_count, 32'd0);
    checkOutput("arst_cur_freq", cur_freq, 32'd0);
    @(posedge ce_clk);
    #1;
    ce_rst_n = 1'b1;
    repeat (2) @(posedge ce_clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
